// File: rtl/data_bus_responder_pkg.sv
// rtl/data_bus_responder_pkg.sv - shared decode constants and helpers for the data bus responder
package data_bus_responder_pkg;

  localparam logic [3:0] REGION_RAM     = 4'h0;
  localparam logic [3:0] TIMER_BASE_DEF = 4'h1;

  typedef enum logic [1:0] {
    OFF_COUNT   = 2'd0,
    OFF_COMPARE = 2'd1,
    OFF_CTRL    = 2'd2,
    OFF_STATUS  = 2'd3
  } timer_off_e;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQEN  = 1;
  localparam int STATUS_PEND = 0;

  // sel[3] covers bits 31:24, matching the core's big-endian lane order.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// rtl/data_bus_responder_if.sv - core data-memory port bundle
interface data_bus_responder_if;

  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        timer_irq_o;

  modport master (
    output ce_i, we_i, addr_i, sel_i, data_i,
    input  data_o, timer_irq_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, sel_i, data_i,
    output data_o, timer_irq_o
  );

endinterface

// File: rtl/data_bus_responder_bus_timer.sv
// rtl/data_bus_responder_bus_timer.sv - free-running timer with compare match and W1C pending flag
module bus_timer
  import data_bus_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  timer_off_e  off_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        pend_q, pend_d;
  logic        match;

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    ctrl_d    = ctrl_q;
    pend_d    = pend_q;

    // Match is judged on pre-write state so same-edge writes cannot mask it.
    match = ctrl_q[CTRL_EN] && (count_q == compare_q);

    if (wr_en_i && (off_i == OFF_COUNT) && (|sel_i)) begin
      count_d = lane_merge(count_q, wdata_i, sel_i);
    end else if (ctrl_q[CTRL_EN]) begin
      count_d = count_q + 32'd1;
    end

    if (wr_en_i && (off_i == OFF_COMPARE)) begin
      compare_d = lane_merge(compare_q, wdata_i, sel_i);
    end

    if (wr_en_i && (off_i == OFF_CTRL) && sel_i[0]) begin
      ctrl_d = wdata_i[1:0];
    end

    if (match) begin
      pend_d = 1'b1;
    end else if (wr_en_i && (off_i == OFF_STATUS) && sel_i[0] && wdata_i[STATUS_PEND]) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'h0000_0000;
      compare_q <= 32'hFFFF_FFFF;
      ctrl_q    <= 2'b00;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ctrl_q    <= ctrl_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    rdata_o = 32'h0000_0000;
    case (off_i)
      OFF_COUNT:   rdata_o = count_q;
      OFF_COMPARE: rdata_o = compare_q;
      OFF_CTRL:    rdata_o = {30'd0, ctrl_q};
      OFF_STATUS:  rdata_o = {31'd0, pend_q};
      default:     rdata_o = 32'h0000_0000;
    endcase
  end

  assign irq_o = pend_q & ctrl_q[CTRL_IRQEN];

endmodule

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - data-memory port responder: region decode, byte-lane RAM, timer
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int         RAM_AW     = 12,
  parameter logic [3:0] TIMER_BASE = TIMER_BASE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  data_bus_responder_if.slave  bus
);

  logic [3:0]        region;
  logic              ram_hit;
  logic              tmr_hit;
  logic              rd_en;
  logic              ram_wr;
  logic              tmr_wr;
  logic [RAM_AW-1:0] word_idx;
  logic [31:0]       ram_rdata;
  logic [31:0]       tmr_rdata;
  logic [31:0]       rdata;
  logic              tmr_irq;
  timer_off_e        tmr_off;
  logic              unused_addr_bits;

  logic [31:0] mem_q [2**RAM_AW];

  assign region   = bus.addr_i[31:28];
  assign ram_hit  = (region == REGION_RAM);
  assign tmr_hit  = (region == TIMER_BASE);
  assign word_idx = bus.addr_i[RAM_AW+1:2];
  assign tmr_off  = timer_off_e'(bus.addr_i[3:2]);
  assign rd_en    = bus.ce_i & ~bus.we_i;
  assign ram_wr   = ~rst & bus.ce_i & bus.we_i & ram_hit;
  assign tmr_wr   = bus.ce_i & bus.we_i & tmr_hit;

  // Alignment is the core's job; upper bits inside a region simply alias.
  assign unused_addr_bits = ^{bus.addr_i[27:RAM_AW+2], bus.addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.sel_i[k]) mem_q[word_idx][8*k +: 8] <= bus.data_i[8*k +: 8];
      end
    end
  end

  assign ram_rdata = mem_q[word_idx];

  bus_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (tmr_wr),
    .off_i   (tmr_off),
    .sel_i   (bus.sel_i),
    .wdata_i (bus.data_i),
    .rdata_o (tmr_rdata),
    .irq_o   (tmr_irq)
  );

  always_comb begin
    rdata = 32'h0000_0000;
    if (rd_en) begin
      if (ram_hit)      rdata = ram_rdata;
      else if (tmr_hit) rdata = tmr_rdata;
    end
  end

  assign bus.data_o      = rdata;
  assign bus.timer_irq_o = tmr_irq;

endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - directed and randomized checks of data_bus_responder against a reference model
module tb_data_bus_responder;

  localparam logic [31:0] T_COUNT   = 32'h1000_0000;
  localparam logic [31:0] T_COMPARE = 32'h1000_0004;
  localparam logic [31:0] T_CTRL    = 32'h1000_0008;
  localparam logic [31:0] T_STATUS  = 32'h1000_000C;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  data_bus_responder_if bus();

  data_bus_responder #(.RAM_AW(12), .TIMER_BASE(4'h1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ram_m [int];
  logic [3:0]  ram_v [int];
  logic [31:0] m_count, m_compare;
  logic        m_en, m_ie, m_pend;
  logic [31:0] rd_obs;
  logic        irq_obs;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  function automatic bit model_known(input logic [31:0] a);
    int key;
    key = int'(a[13:2]);
    if (a[31:28] != 4'h0) return 1'b1;
    return ram_v.exists(key) && (ram_v[key] == 4'hF);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int key;
    key = int'(a[13:2]);
    if (a[31:28] == 4'h0) return ram_v.exists(key) ? ram_m[key] : 32'h0;
    if (a[31:28] != 4'h1) return 32'h0;
    case (a[3:2])
      2'd0:    return m_count;
      2'd1:    return m_compare;
      2'd2:    return {30'd0, m_ie, m_en};
      default: return {31'd0, m_pend};
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic c, input logic w,
                            input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bit match, twr;
    int key;
    if (r) begin
      m_count = 0; m_compare = 32'hFFFF_FFFF; m_en = 0; m_ie = 0; m_pend = 0;
      return;
    end
    match = m_en && (m_count == m_compare);
    twr   = c && w && (a[31:28] == 4'h1);
    if (twr && a[3:2] == 2'd0 && s != 4'h0) m_count = merge(m_count, d, s);
    else if (m_en)                           m_count = m_count + 1;
    if (twr && a[3:2] == 2'd1) m_compare = merge(m_compare, d, s);
    if (twr && a[3:2] == 2'd2 && s[0]) begin
      m_en = d[0];
      m_ie = d[1];
    end
    if (match) m_pend = 1'b1;
    else if (twr && a[3:2] == 2'd3 && s[0] && d[0]) m_pend = 1'b0;
    if (c && w && a[31:28] == 4'h0) begin
      key = int'(a[13:2]);
      if (!ram_v.exists(key)) begin
        ram_v[key] = 4'h0;
        ram_m[key] = 32'h0;
      end
      ram_m[key] = merge(ram_m[key], d, s);
      ram_v[key] = ram_v[key] | s;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic c, input logic w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d, input string tag);
    @(negedge clk);
    rst = r; bus.ce_i = c; bus.we_i = w; bus.addr_i = a; bus.sel_i = s; bus.data_i = d;
    #1;
    rd_obs  = bus.data_o;
    irq_obs = bus.timer_irq_o;
    if (!(c && !w)) chk({tag, "_idle"}, rd_obs, 32'h0);
    else if (model_known(a)) chk({tag, "_model"}, rd_obs, model_read(a));
    chk({tag, "_irq"}, {31'd0, irq_obs}, {31'd0, m_pend & m_ie});
    @(posedge clk);
    model_edge(r, c, w, a, s, d);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b1, a, s, d, "wr");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    cyc(1'b0, 1'b1, 1'b0, a, 4'hF, 32'h0, tag);
    chk(tag, rd_obs, exp);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    int          pick;
    rst = 1'b1; bus.ce_i = 0; bus.we_i = 0; bus.addr_i = 0; bus.sel_i = 0; bus.data_i = 0;
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, "reset");
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, "reset");

    rd(T_COUNT,   32'h0000_0000, "rst_count");
    rd(T_COMPARE, 32'hFFFF_FFFF, "rst_compare");
    rd(T_CTRL,    32'h0000_0000, "rst_ctrl");
    rd(T_STATUS,  32'h0000_0000, "rst_status");

    wr(32'h10, 4'hF, 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF, "ram_full");
    wr(32'h10, 4'h1, 32'h0000_00AA);
    rd(32'h10, 32'hDEAD_BEAA, "ram_lane0");
    wr(32'h20, 4'hF, 32'h0);
    wr(32'h20, 4'h8, 32'h1200_0000);
    rd(32'h20, 32'h1200_0000, "ram_lane3");
    cyc(1'b0, 1'b0, 1'b0, 32'h20, 4'hF, 32'h0, "ce_low");
    chk("ce_low_zero", rd_obs, 32'h0);

    wr(T_COMPARE, 4'hF, 32'd5);
    wr(T_CTRL,    4'hF, 32'd3);
    for (int i = 0; i < 6; i++) begin
      rd(T_COUNT, i, "count_run");
      chk("irq_before_match", {31'd0, irq_obs}, 32'h0);
    end
    rd(T_COUNT, 32'd6, "count_after_match");
    chk("irq_after_match", {31'd0, irq_obs}, 32'h1);
    wr(T_STATUS, 4'hF, 32'h1);
    rd(T_STATUS, 32'h0, "w1c_clear");
    chk("irq_after_w1c", {31'd0, irq_obs}, 32'h0);

    wr(T_COMPARE, 4'hF, 32'hFFFF_FFFF);
    wr(T_COUNT,   4'hF, 32'hFFFF_FFFE);
    rd(T_COUNT, 32'hFFFF_FFFE, "count_written");
    rd(T_COUNT, 32'hFFFF_FFFF, "count_max");
    rd(T_COUNT, 32'h0000_0000, "count_wrap");
    chk("irq_at_wrap", {31'd0, irq_obs}, 32'h1);

    wr(T_STATUS,  4'hF, 32'h1);
    wr(T_COMPARE, 4'hF, 32'h103);
    wr(T_COUNT,   4'hF, 32'h100);
    rd(T_COUNT, 32'h100, "count_bus_write");
    rd(T_COUNT, 32'h101, "count_resume");
    rd(T_COUNT, 32'h102, "count_resume2");
    wr(T_STATUS, 4'hF, 32'h1);
    rd(T_STATUS, 32'h1, "set_beats_clear");

    cyc(1'b1, 1'b1, 1'b1, T_COUNT, 4'hF, 32'h5555, "rst_mid");
    rd(T_COUNT,   32'h0,         "rst2_count");
    chk("rst2_irq", {31'd0, irq_obs}, 32'h0);
    rd(T_COMPARE, 32'hFFFF_FFFF, "rst2_compare");
    rd(T_CTRL,    32'h0,         "rst2_ctrl");
    rd(T_STATUS,  32'h0,         "rst2_status");

    rd(32'h2000_0000, 32'h0, "other_read");
    wr(32'h2000_0000, 4'hF, 32'hFFFF_FFFF);
    wr(32'h2000_0010, 4'hF, 32'hFFFF_FFFF);
    rd(32'h10,      32'hDEAD_BEAA, "other_ram_intact");
    rd(T_COMPARE,   32'hFFFF_FFFF, "other_tmr_intact");
    rd(T_CTRL,      32'h0,         "other_ctrl_intact");

    for (int n = 0; n < 600; n++) begin
      pick = $urandom_range(0, 19);
      s    = 4'($urandom);
      d    = $urandom;
      if (pick < 9) begin
        a = {18'd0, 10'($urandom_range(0, 15)), 2'($urandom)};
        a = {a[31:6], 6'(a[3:0] << 2) | 6'($urandom_range(0, 3))};
        cyc(1'b0, 1'b1, 1'($urandom), a, s, d, "rnd_ram");
      end else if (pick < 16) begin
        a = {4'h1, 24'($urandom), 2'($urandom), 2'($urandom)};
        if (a[3:2] == 2'd1) d = m_count + 32'($urandom_range(0, 4));
        if (a[3:2] == 2'd2 && $urandom_range(0, 3) != 0) d = 32'h3;
        cyc(1'b0, 1'b1, 1'($urandom), a, s, d, "rnd_tmr");
      end else if (pick < 18) begin
        a = {4'($urandom_range(2, 15)), 28'($urandom)};
        cyc(1'b0, 1'b1, 1'($urandom), a, s, d, "rnd_other");
      end else if (pick == 18) begin
        cyc(1'b0, 1'b0, 1'($urandom), $urandom, s, d, "rnd_idle");
      end else begin
        cyc(($urandom_range(0, 9) == 0), 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, "rnd_rst");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
